// File: rtl/buffer_reader.sv
// buffer_reader: streams a stored image out of the 4-bank pixel buffer as 32-bit words.
// One bank read is issued per cycle, gated so that the output FIFO can always absorb
// every read still in flight. The final partial word has its unused bytes zeroed.
// Optional macro BUFFER_READER_STATS_EN adds a saturating stall_cycles counter port.
module buffer_reader #(
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [9:0]  rows,
  input  logic [9:0]  cols,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [16:0] rd_address,
  input  logic [31:0] rd_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
`ifdef BUFFER_READER_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t      state_q, state_d;
  logic [17:0] total_q, total_d;
  logic [17:0] issued_q, issued_d;
  logic [1:0]  rem_q, rem_d;

  // vld_pipe_q[i]: a read issued i+1 cycles ago; lst_pipe_q tags the image's final word
  logic [RAM_LATENCY-1:0] vld_pipe_q, lst_pipe_q;

  logic [32:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  logic [19:0] prod;
  logic [17:0] total_calc;
  logic        start_acc;
  logic [7:0]  inflight;
  logic [7:0]  occ;
  logic        issue_last;
  logic        push, push_last, pop;
  logic [31:0] push_data;

  assign prod       = {10'd0, rows} * {10'd0, cols};
  assign total_calc = 18'((21'(prod) + 21'd3) >> 2);
  assign start_acc  = start && (state_q == IDLE);
  assign issue_last = (issued_q == total_q - 18'd1);
  assign push       = vld_pipe_q[RAM_LATENCY-1];
  assign push_last  = lst_pipe_q[RAM_LATENCY-1];
  assign out_valid  = (cnt_q != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = fifo_mem_q[rd_ptr_q][31:0];
  assign out_last   = fifo_mem_q[rd_ptr_q][32] && out_valid;
  assign rd_address = issued_q[16:0];
  assign busy       = (state_q == READ) || (state_q == DRAIN);
  assign done       = (state_q == FINISH);

  // Occupancy seen by the issue gate: queued words plus reads not yet returned
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + 8'(vld_pipe_q[i]);
    occ   = 8'(cnt_q) + inflight;
    rd_en = (state_q == READ) && (occ < 8'(FIFO_DEPTH));
  end

  // Zero the bytes past the last pixel when the image does not fill its final word
  always_comb begin
    push_data = rd_data;
    if (push_last && rem_q != 2'd0) begin
      for (int k = 0; k < 4; k++)
        if (2'(k) >= rem_q) push_data[8*k +: 8] = 8'h00;
    end
  end

  // Next-state logic: capture geometry on start, count issued reads, wait for last handshake
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    issued_d = issued_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE: if (start) begin
        total_d  = total_calc;
        rem_d    = prod[1:0];
        issued_d = '0;
        state_d  = (total_calc == '0) ? FINISH : READ;
      end
      READ: if (rd_en) begin
        issued_d = issued_q + 18'd1;
        if (issue_last) state_d = DRAIN;
      end
      DRAIN:   if (pop && out_last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      total_q  <= '0;
      issued_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      rem_q    <= rem_d;
    end
  end

  // RAM latency tracker: shifts each issued read toward its capture cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en;
      lst_pipe_q[0] <= rd_en && issue_last;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        lst_pipe_q[i] <= lst_pipe_q[i-1];
      end
    end
  end

  // Output FIFO: storage, pointers and count; push and pop may coincide
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef BUFFER_READER_STATS_EN
  logic [31:0] stall_cycles_q;
  assign stall_cycles = stall_cycles_q;

  // Back-pressure counter: restarts on each accepted start, saturates, frozen when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_cycles_q <= '0;
    else if (start_acc)
      stall_cycles_q <= '0;
    else if (busy && out_valid && !out_ready && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: table of images plus reset-abort and stall sequences.
module tb_buffer_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rows = '0, cols = '0;
  logic        start = 1'b0;
  logic        busy, done, rd_en, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [16:0] rd_address;
  logic [31:0] rd_data = '0;
  logic [31:0] out_data;
`ifdef BUFFER_READER_STATS_EN
  logic [31:0] stall_cycles;
`endif

  buffer_reader dut (
    .clock(clock), .reset_n(reset_n), .rows(rows), .cols(cols), .start(start),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef BUFFER_READER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [16:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4 * int'(a) + k);
    return w;
  endfunction

  // Bank RAM model, one-cycle read latency
  always @(posedge clock) if (rd_en) rd_data <= ram_word(rd_address);

  // Expected output word i for an image of px pixels
  function automatic logic [31:0] exp_word(input int i, input int px);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = (4 * i + k < px) ? 8'(4 * i + k) : 8'h00;
    return w;
  endfunction

  // out_ready modes: 0 held high, 1 toggling, 2 low for the first 5 valid cycles
  int mode = 0;
  int valid_seen = 0;
  always begin
    @(posedge clock); #1;
    case (mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = (valid_seen >= 5);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: collects handshaken words and protocol violations at the falling edge
  logic        mon_clr = 1'b0;
  logic [32:0] words[$];
  int n_rd, n_pop, gate_err, addr_err, stab_err, busy_err, done_cnt, done_cyc, hs_cyc;
  int first_rd, first_vld;
  logic        prev_stall;
  logic [32:0] prev_word;
  always @(negedge clock) begin
    if (mon_clr) begin
      words.delete();
      n_rd = 0; n_pop = 0; gate_err = 0; addr_err = 0; stab_err = 0; busy_err = 0;
      done_cnt = 0; done_cyc = -1; hs_cyc = -1; first_rd = -1; first_vld = -1;
      valid_seen = 0; prev_stall = 1'b0; prev_word = '0;
    end else if (reset_n) begin
      if (prev_stall && (!out_valid || {out_last, out_data} != prev_word)) stab_err++;
      if (rd_en) begin
        if (n_rd - n_pop >= 4) gate_err++;
        if (rd_address != 17'(n_rd)) addr_err++;
        if (n_rd == 0) first_rd = cyc;
        n_rd++;
      end
      if (out_valid) begin
        if (valid_seen == 0) first_vld = cyc;
        valid_seen++;
      end
      if (out_valid && out_ready) begin
        words.push_back({out_last, out_data});
        n_pop++;
        hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_err++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clock); #1 mon_clr = 1'b1;
    @(posedge clock); #1 mon_clr = 1'b0;
  endtask

  int start_cyc;
  task automatic run_img(input int r, input int c, input int m);
    int budget;
    mode = m;
    clear_mon();
    rows = 10'(r); cols = 10'(c); start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1 start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 2000) begin @(posedge clock); budget++; end
    if (done_cnt == 0) chk("done_timeout", 64'(0), 64'(1));
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_img(input string tag, input int r, input int c,
                           input int nw, input logic [31:0] lastw);
    int px;
    px = r * c;
    chk({tag, "_nwords"}, 64'(words.size()), 64'(nw));
    chk({tag, "_nreads"}, 64'(n_rd), 64'(nw));
    for (int i = 0; i < words.size() && i < nw; i++) begin
      chk($sformatf("%s_w%0d", tag, i), 64'(words[i]), 64'({(i == nw - 1), exp_word(i, px)}));
    end
    if (nw > 0) begin
      chk({tag, "_lastword"}, 64'(words[words.size() - 1]), 64'({1'b1, lastw}));
      chk({tag, "_done_after_hs"}, 64'(done_cyc), 64'(hs_cyc + 1));
      chk({tag, "_first_latency"}, 64'(first_vld), 64'(first_rd + 2));
    end else begin
      chk({tag, "_done_empty"}, 64'(done_cyc), 64'(start_cyc + 1));
      chk({tag, "_no_valid"}, 64'(valid_seen), 64'(0));
    end
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    chk({tag, "_gate"}, 64'(gate_err), 64'(0));
    chk({tag, "_addr"}, 64'(addr_err), 64'(0));
    chk({tag, "_stable"}, 64'(stab_err), 64'(0));
    chk({tag, "_busy_at_done"}, 64'(busy_err), 64'(0));
    chk({tag, "_idle_after"}, 64'({busy, out_valid}), 64'(0));
  endtask

  typedef struct {
    int          r;
    int          c;
    int          m;
    int          nw;
    logic [31:0] lastw;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{r: 4,  c: 4,  m: 0, nw: 4,  lastw: 32'h0F0E0D0C};
    vecs[1] = '{r: 3,  c: 3,  m: 0, nw: 3,  lastw: 32'h00000008};
    vecs[2] = '{r: 10, c: 10, m: 1, nw: 25, lastw: 32'h63626160};
    vecs[3] = '{r: 0,  c: 5,  m: 0, nw: 0,  lastw: 32'h00000000};
    vecs[4] = '{r: 1,  c: 1,  m: 0, nw: 1,  lastw: 32'h00000000};
    vecs[5] = '{r: 2,  c: 3,  m: 1, nw: 2,  lastw: 32'h00000504};
    vecs[6] = '{r: 5,  c: 7,  m: 1, nw: 9,  lastw: 32'h00222120};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 64'({busy, done, rd_en, rd_address, out_valid, out_last, out_data}), 64'(0));
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_img(vecs[i].r, vecs[i].c, vecs[i].m);
      check_img($sformatf("v%0d", i), vecs[i].r, vecs[i].c, vecs[i].nw, vecs[i].lastw);
    end

    // Start while done is high is ignored; a fresh start afterwards works
    begin
      mode = 0;
      clear_mon();
      rows = 10'd0; cols = 10'd1; start = 1'b1;
      @(posedge clock); #1;
      chk("finish_state_done", 64'(done), 64'(1));
      rows = 10'd4; cols = 10'd4;
      @(posedge clock); #1;
      start = 1'b0;
      chk("start_in_finish_ignored", 64'(busy), 64'(0));
      repeat (2) @(posedge clock);
      #1;
    end

    // Reset in the middle of a 25-word image, then a single-word image
    begin
      int budget;
      mode = 0;
      clear_mon();
      rows = 10'd10; cols = 10'd10; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      budget = 0;
      while (words.size() < 10 && budget < 200) begin @(posedge clock); budget++; end
      if (words.size() < 10) chk("abort_timeout", 64'(0), 64'(1));
      #1 reset_n = 1'b0;
      #1;
      chk("abort_outputs", 64'({busy, done, rd_en, rd_address, out_valid, out_last, out_data}), 64'(0));
      @(posedge clock); #1 reset_n = 1'b1;
      chk("abort_no_done", 64'(done_cnt), 64'(0));
      run_img(2, 2, 0);
      check_img("post_reset", 2, 2, 1, 32'h03020100);
    end

`ifdef BUFFER_READER_STATS_EN
    run_img(4, 4, 2);
    check_img("stall", 4, 4, 4, 32'h0F0E0D0C);
    chk("stall_cycles", 64'(stall_cycles), 64'(5));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
